// File: rtl/bank_queue_mc.sv
// Multi-channel bank queue counter: per-queue occupancy, flags, wait estimate and a branch total.
// Photocell inputs are asynchronous and active-low; each low level counts as exactly one event.
module bank_queue_mc #(
    parameter int unsigned N_Q     = 2,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned T_W     = 2,
    parameter int unsigned SVC_T   = 3,
    parameter int unsigned CNT_MAX = (1 << CNT_W) - 1,
    parameter int unsigned TMAX    = (1 << T_W) - 1,
    parameter int unsigned WAIT_W  = $clog2(SVC_T * (CNT_MAX + TMAX - 1) + 1),
    parameter int unsigned TOT_W   = $clog2(N_Q * CNT_MAX + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_Q-1:0]          phc_in_n,
    input  logic [N_Q-1:0]          phc_out_n,
    input  logic [N_Q*T_W-1:0]      tcount,
    output logic [N_Q*CNT_W-1:0]    pcount,
    output logic [N_Q*WAIT_W-1:0]   pwait,
    output logic [N_Q-1:0]          empty,
    output logic [N_Q-1:0]          full,
    output logic [N_Q-1:0]          closed,
    output logic [N_Q-1:0]          reject,
    output logic [N_Q-1:0]          underflow,
    output logic [TOT_W-1:0]        total
);

    localparam logic [CNT_W-1:0]  L_CNT_MAX = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]  L_CNT_ONE = CNT_W'(1);
    localparam logic [WAIT_W-1:0] L_SVC     = WAIT_W'(SVC_T);
    localparam logic [WAIT_W-1:0] L_W_ONE   = WAIT_W'(1);

    logic [N_Q-1:0] r_in_s1;
    logic [N_Q-1:0] r_in_s2;
    logic [N_Q-1:0] r_in_h;
    logic [N_Q-1:0] r_out_s1;
    logic [N_Q-1:0] r_out_s2;
    logic [N_Q-1:0] r_out_h;
    logic [N_Q-1:0] w_arr;
    logic [N_Q-1:0] w_dep;

    // Idle-high reset values so releasing reset never looks like a falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_s1  <= '1;
            r_in_s2  <= '1;
            r_in_h   <= '1;
            r_out_s1 <= '1;
            r_out_s2 <= '1;
            r_out_h  <= '1;
        end else begin
            r_in_s1  <= phc_in_n;
            r_in_s2  <= r_in_s1;
            r_in_h   <= r_in_s2;
            r_out_s1 <= phc_out_n;
            r_out_s2 <= r_out_s1;
            r_out_h  <= r_out_s2;
        end
    end

    assign w_arr = r_in_h & ~r_in_s2;
    assign w_dep = r_out_h & ~r_out_s2;

    for (genvar q = 0; q < N_Q; q++) begin : g_q
        logic [CNT_W-1:0]  r_cnt;
        logic [CNT_W-1:0]  w_cnt_d;
        logic              r_rej;
        logic              w_rej_d;
        logic              r_unf;
        logic              w_unf_d;
        logic              r_closed;
        logic [WAIT_W-1:0] r_wait;
        logic [WAIT_W-1:0] w_wait_d;
        logic [T_W-1:0]    w_t;
        logic [WAIT_W-1:0] w_p_ext;
        logic [WAIT_W-1:0] w_t_ext;
        logic [WAIT_W-1:0] w_num;

        assign w_t     = tcount[q*T_W +: T_W];
        assign w_p_ext = WAIT_W'(r_cnt);
        assign w_t_ext = WAIT_W'(w_t);
        // WAIT_W is sized to hold SVC_T*(CNT_MAX+TMAX-1), so the numerator never truncates.
        assign w_num   = L_SVC * (w_p_ext + w_t_ext - L_W_ONE);

        always_comb begin
            w_cnt_d = r_cnt;
            w_rej_d = 1'b0;
            w_unf_d = 1'b0;
            unique case ({w_arr[q], w_dep[q]})
                2'b10: begin
                    if (r_cnt == L_CNT_MAX) w_rej_d = 1'b1;
                    else                    w_cnt_d = r_cnt + L_CNT_ONE;
                end
                2'b01: begin
                    if (r_cnt == '0) w_unf_d = 1'b1;
                    else             w_cnt_d = r_cnt - L_CNT_ONE;
                end
                2'b11: begin
                    // Departure has nobody to serve, so the arrival alone lands.
                    if (r_cnt == '0) begin
                        w_cnt_d = L_CNT_ONE;
                        w_unf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        always_comb begin
            w_wait_d = '0;
            if (r_cnt == '0)     w_wait_d = '0;
            else if (w_t == '0)  w_wait_d = '1;
            else                 w_wait_d = w_num / w_t_ext;
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_cnt    <= '0;
                r_rej    <= 1'b0;
                r_unf    <= 1'b0;
                r_closed <= 1'b0;
                r_wait   <= '0;
            end else begin
                r_cnt    <= w_cnt_d;
                r_rej    <= w_rej_d;
                r_unf    <= w_unf_d;
                r_closed <= (w_t == '0);
                r_wait   <= w_wait_d;
            end
        end

        assign pcount[q*CNT_W +: CNT_W]  = r_cnt;
        assign pwait[q*WAIT_W +: WAIT_W] = r_wait;
        assign empty[q]                  = (r_cnt == '0);
        assign full[q]                   = (r_cnt == L_CNT_MAX);
        assign closed[q]                 = r_closed;
        assign reject[q]                 = r_rej;
        assign underflow[q]              = r_unf;
    end

    logic [TOT_W-1:0] w_sum;
    logic [TOT_W-1:0] r_total;

    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < N_Q; i++) begin
            w_sum = w_sum + TOT_W'(pcount[i*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_total <= '0;
        else       r_total <= w_sum;
    end

    assign total = r_total;

endmodule
